// File: rtl/fetch_ctrl.sv
// IF-stage controller: PC register, IF/ID register, stall/flush event counters; 1-cycle fetch latency.
// Backpressure: pcwrite_i/IFIDwrite_i hold PC and IF/ID independently; start_i=0 freezes everything.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             pcwrite_i,
    input  logic             IFIDwrite_i,
    input  logic             flush_i,
    input  logic [31:0]      branch_target_i,
    input  logic [31:0]      instr_i,
    output logic [31:0]      pc_o,
    output logic [31:0]      IFIDpc_o,
    output logic [31:0]      IFIDinstr_o,
    output logic             IFIDvalid_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_STALL,
        ST_REDIRECT
    } state_e;

    state_e state;

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      ifid_pc_q, ifid_pc_d;
    logic [31:0]      ifid_instr_q, ifid_instr_d;
    logic             ifid_vld_q, ifid_vld_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [31:0]      pc_seq;

    assign pc_seq = pc_q + 32'd4;

    // A branch held in a stalled ID stage has no final outcome, so STALL outranks REDIRECT.
    always_comb begin
        state = ST_RUN;
        if (!start_i) begin
            state = ST_IDLE;
        end else if (!pcwrite_i) begin
            state = ST_STALL;
        end else if (flush_i) begin
            state = ST_REDIRECT;
        end
    end

    always_comb begin
        pc_d         = pc_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_vld_d   = ifid_vld_q;
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;

        case (state)
            ST_RUN:      pc_d = pc_seq;
            ST_REDIRECT: pc_d = branch_target_i;
            default:     pc_d = pc_q;
        endcase

        // IF/ID enable is honoured on its own, even while the PC is held.
        if (state != ST_IDLE && IFIDwrite_i) begin
            ifid_pc_d = pc_seq;
            if (state == ST_REDIRECT) begin
                ifid_instr_d = 32'h0;
                ifid_vld_d   = 1'b0;
            end else begin
                ifid_instr_d = instr_i;
                ifid_vld_d   = 1'b1;
            end
        end

        if (state == ST_STALL && stall_cnt_q != {CNT_W{1'b1}}) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (state == ST_REDIRECT && flush_cnt_q != {CNT_W{1'b1}}) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc_q         <= RESET_PC;
            ifid_pc_q    <= 32'h0;
            ifid_instr_q <= 32'h0;
            ifid_vld_q   <= 1'b0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            pc_q         <= pc_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_vld_q   <= ifid_vld_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign pc_o        = pc_q;
    assign IFIDpc_o    = ifid_pc_q;
    assign IFIDinstr_o = ifid_instr_q;
    assign IFIDvalid_o = ifid_vld_q;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: stimulus queues hand-computed expectations, a negedge monitor checks them.
module tb_fetch_ctrl;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ifpc;
        logic [31:0] instr;
        logic        vld;
        logic [15:0] sc;
        logic [15:0] fc;
        int          id;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // instance A: default parameters
    logic        rst_a = 1'b0, start_a = 1'b0, pcw_a = 1'b1, ifw_a = 1'b1, fl_a = 1'b0;
    logic [31:0] tgt_a = 32'h0;
    logic [31:0] instr_a, pc_a, ifpc_a, ifinstr_a;
    logic        vld_a;
    logic [15:0] sc_a, fc_a;

    // instance B: wrap-around reset PC and narrow counters
    logic        rst_b = 1'b0, start_b = 1'b0, pcw_b = 1'b1, fl_b = 1'b0;
    logic [31:0] tgt_b = 32'h0;
    logic [31:0] instr_b, pc_b, ifpc_b, ifinstr_b;
    logic        vld_b;
    logic [3:0]  sc_b, fc_b;

    // instruction memory image: each word encodes its own address
    assign instr_a = 32'h1000_0000 | pc_a;
    assign instr_b = 32'h1000_0000 | pc_b;

    fetch_ctrl u_a (
        .clk_i(clk), .rst_i(rst_a), .start_i(start_a), .pcwrite_i(pcw_a), .IFIDwrite_i(ifw_a),
        .flush_i(fl_a), .branch_target_i(tgt_a), .instr_i(instr_a), .pc_o(pc_a),
        .IFIDpc_o(ifpc_a), .IFIDinstr_o(ifinstr_a), .IFIDvalid_o(vld_a),
        .stall_cnt_o(sc_a), .flush_cnt_o(fc_a)
    );

    fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(4)) u_b (
        .clk_i(clk), .rst_i(rst_b), .start_i(start_b), .pcwrite_i(pcw_b), .IFIDwrite_i(pcw_b),
        .flush_i(fl_b), .branch_target_i(tgt_b), .instr_i(instr_b), .pc_o(pc_b),
        .IFIDpc_o(ifpc_b), .IFIDinstr_o(ifinstr_b), .IFIDvalid_o(vld_b),
        .stall_cnt_o(sc_b), .flush_cnt_o(fc_b)
    );

    int   total = 0;
    int   bad   = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s #%0d actual=%h required=%h", nm, id, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (qa.size() > 0) begin
            ea = qa.pop_front();
            chk("a_pc", ea.id, pc_a, ea.pc);
            chk("a_ifpc", ea.id, ifpc_a, ea.ifpc);
            chk("a_instr", ea.id, ifinstr_a, ea.instr);
            chk("a_valid", ea.id, {31'b0, vld_a}, {31'b0, ea.vld});
            chk("a_stall_cnt", ea.id, {16'b0, sc_a}, {16'b0, ea.sc});
            chk("a_flush_cnt", ea.id, {16'b0, fc_a}, {16'b0, ea.fc});
        end
        if (qb.size() > 0) begin
            eb = qb.pop_front();
            chk("b_pc", eb.id, pc_b, eb.pc);
            chk("b_ifpc", eb.id, ifpc_b, eb.ifpc);
            chk("b_stall_cnt", eb.id, {28'b0, sc_b}, {16'b0, eb.sc});
            chk("b_flush_cnt", eb.id, {28'b0, fc_b}, {16'b0, eb.fc});
        end
    end

    int sid = 0;

    task automatic step_a(input logic s, input logic pw, input logic iw, input logic fl,
                          input logic [31:0] tgt, input logic [31:0] epc, input logic [31:0] eifpc,
                          input logic [31:0] einstr, input logic ev, input logic [15:0] esc,
                          input logic [15:0] efc);
        exp_t e;
        start_a = s; pcw_a = pw; ifw_a = iw; fl_a = fl; tgt_a = tgt;
        @(posedge clk);
        #1;
        sid++;
        e = '{pc: epc, ifpc: eifpc, instr: einstr, vld: ev, sc: esc, fc: efc, id: sid};
        qa.push_back(e);
    endtask

    task automatic step_b(input logic s, input logic pw, input logic fl, input logic [31:0] tgt,
                          input logic [31:0] epc, input logic [31:0] eifpc,
                          input logic [15:0] esc, input logic [15:0] efc);
        exp_t e;
        start_b = s; pcw_b = pw; fl_b = fl; tgt_b = tgt;
        @(posedge clk);
        #1;
        sid++;
        e = '{pc: epc, ifpc: eifpc, instr: 32'h0, vld: 1'b0, sc: esc, fc: efc, id: sid};
        qb.push_back(e);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        #1;
        e = '{pc: 32'h0, ifpc: 32'h0, instr: 32'h0, vld: 1'b0, sc: 16'd0, fc: 16'd0, id: 0};
        qa.push_back(e);
        #11;
        rst_a = 1'b1;

        // run: pc 0 -> 4 -> 8
        step_a(1, 1, 1, 0, 32'h0, 32'h4, 32'h4, 32'h1000_0000, 1, 0, 0);
        step_a(1, 1, 1, 0, 32'h0, 32'h8, 32'h8, 32'h1000_0004, 1, 0, 0);
        // load-use stall for two cycles at pc 8
        step_a(1, 0, 0, 0, 32'h0, 32'h8, 32'h8, 32'h1000_0004, 1, 1, 0);
        step_a(1, 0, 0, 0, 32'h0, 32'h8, 32'h8, 32'h1000_0004, 1, 2, 0);
        step_a(1, 1, 1, 0, 32'h0, 32'hC, 32'hC, 32'h1000_0008, 1, 2, 0);
        step_a(1, 1, 1, 0, 32'h0, 32'h10, 32'h10, 32'h1000_000C, 1, 2, 0);
        // branch flush at pc 16 to 0x40, then target instruction
        step_a(1, 1, 1, 1, 32'h40, 32'h40, 32'h14, 32'h0, 0, 2, 1);
        step_a(1, 1, 1, 0, 32'h0, 32'h44, 32'h44, 32'h1000_0040, 1, 2, 1);
        // flush during stall ignored, then accepted next cycle
        step_a(1, 0, 0, 1, 32'h80, 32'h44, 32'h44, 32'h1000_0040, 1, 3, 1);
        step_a(1, 1, 1, 1, 32'h80, 32'h80, 32'h48, 32'h0, 0, 3, 2);
        // start low: frozen despite flush and stall inputs
        for (int i = 0; i < 3; i++)
            step_a(0, 0, 1, 1, 32'h200, 32'h80, 32'h48, 32'h0, 0, 3, 2);
        // independent enables
        step_a(1, 0, 1, 0, 32'h0, 32'h80, 32'h84, 32'h1000_0080, 1, 4, 2);
        step_a(1, 1, 0, 0, 32'h0, 32'h84, 32'h84, 32'h1000_0080, 1, 4, 2);
        step_a(1, 1, 0, 1, 32'h100, 32'h100, 32'h84, 32'h1000_0080, 1, 4, 3);
        step_a(1, 1, 1, 0, 32'h0, 32'h104, 32'h104, 32'h1000_0100, 1, 4, 3);
        // async reset between edges during a stall
        step_a(1, 0, 0, 1, 32'h300, 32'h104, 32'h104, 32'h1000_0100, 1, 5, 3);
        @(negedge clk);
        #2;
        rst_a = 1'b0;
        #1;
        chk("async_pc", sid, pc_a, 32'h0);
        chk("async_ifpc", sid, ifpc_a, 32'h0);
        chk("async_instr", sid, ifinstr_a, 32'h0);
        chk("async_valid", sid, {31'b0, vld_a}, 32'h0);
        chk("async_cnts", sid, {sc_a, fc_a}, 32'h0);
        @(posedge clk);
        #1;
        chk("held_reset_pc", sid, pc_a, 32'h0);
        rst_a = 1'b1;
        step_a(1, 1, 1, 0, 32'h0, 32'h4, 32'h4, 32'h1000_0000, 1, 0, 0);

        // instance B: PC wrap and counter saturation
        e = '{pc: 32'hFFFF_FFFC, ifpc: 32'h0, instr: 32'h0, vld: 1'b0, sc: 16'd0, fc: 16'd0, id: 900};
        qb.push_back(e);
        @(negedge clk);
        #2;
        rst_b = 1'b1;
        step_b(1, 1, 0, 32'h0, 32'h0, 32'h0, 0, 0);
        for (int k = 1; k <= 20; k++)
            step_b(1, 0, 0, 32'h0, 32'h0, 32'h0, (k > 15) ? 16'd15 : 16'(k), 0);
        for (int k = 1; k <= 17; k++)
            step_b(1, 1, 1, 32'h200, 32'h200, (k == 1) ? 32'h4 : 32'h204, 15,
                   (k > 15) ? 16'd15 : 16'(k));

        @(negedge clk);
        #1;
        chk("qa_drained", 0, qa.size(), 0);
        chk("qb_drained", 0, qb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
